// File: rtl/dmg_bus_pkg.sv
// -----------------------------------------------------------------------------
// dmg_bus_pkg
// Shared definitions for the DL bus arbitration logic in the sequencer:
//   - requester index constants for the four DL drivers
//   - dl_arb_state_t : arbiter FSM state encoding
//   - rr_pick()      : round-robin winner search over a request vector
// -----------------------------------------------------------------------------
package dmg_bus_pkg;

  // Widest supported requester vector and the index width that covers it.
  localparam int REQ_MAX = 8;
  localparam int IDX_W   = 3;
  // Hold counter width; covers MAX_HOLD up to 15.
  localparam int HOLD_W  = 4;

  // DL driver indices as wired by the decoder.
  localparam int REQ_BRIDGE = 0;
  localparam int REQ_REGF   = 1;
  localparam int REQ_IMM    = 2;
  localparam int REQ_EXT    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } dl_arb_state_t;

  // Returns the first set bit of req searching upward from ptr, wrapping at
  // nreq. ptr must be < nreq. Returns ptr when no bit is set; the caller
  // qualifies the result with |req.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [REQ_MAX-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 nreq
  );
    logic [IDX_W-1:0] win;
    int               idx;
    win = ptr;
    // Walk the distances from far to near so the nearest hit is written last.
    for (int k = REQ_MAX - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && req[idx[IDX_W-1:0]]) win = idx[IDX_W-1:0];
    end
    return win;
  endfunction

endpackage

// File: rtl/dl_rr_pick.sv
// -----------------------------------------------------------------------------
// dl_rr_pick
// Purely combinational round-robin winner selection for the DL arbiter.
// Ports:
//   req_i     [NREQ-1:0]  request vector
//   rr_ptr_i  [IDX_W-1:0] search start index (< NREQ)
//   winner_o  [IDX_W-1:0] index of the winning requester
//   valid_o               at least one request present; winner_o meaningful
// -----------------------------------------------------------------------------
module dl_rr_pick
  import dmg_bus_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [REQ_MAX-1:0] req_ext;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req_i;
  end

  assign winner_o = rr_pick(req_ext, rr_ptr_i, NREQ);
  assign valid_o  = |req_i;

endmodule

// File: rtl/dl_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dl_bus_arbiter
// Sequences ownership of the internal data bus DL among NREQ drivers. One
// owner at a time, a one-cycle precharge turnaround between owners, and a
// bounded hold time of MAX_HOLD cycles per grant.
// Ports:
//   CLK2       clock, rising edge
//   RESET      asynchronous, active-high reset
//   req        [NREQ-1:0] level requests from the decoder, held until granted
//   grant      [NREQ-1:0] registered one-hot-or-zero ownership
//   DataOut    grant[BRIDGE_IDX], drives the data bridge
//   bus_busy   high while OWNED or TURN
//   precharge  high in TURN; DL released to all-ones
//   overrun    one-cycle pulse (during TURN) when MAX_HOLD forced the release
// -----------------------------------------------------------------------------
module dl_bus_arbiter
  import dmg_bus_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MAX_HOLD   = 4,
  parameter int BRIDGE_IDX = REQ_BRIDGE
) (
  input  logic            CLK2,
  input  logic            RESET,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            DataOut,
  output logic            bus_busy,
  output logic            precharge,
  output logic            overrun
);

  if (NREQ < 2 || NREQ > REQ_MAX) begin : g_bad_nreq
    $error("dl_bus_arbiter: NREQ must be 2..8");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
    $error("dl_bus_arbiter: MAX_HOLD must be 1..15");
  end
  if (BRIDGE_IDX < 0 || BRIDGE_IDX >= NREQ) begin : g_bad_bridge
    $error("dl_bus_arbiter: BRIDGE_IDX out of range");
  end

  dl_arb_state_t      state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               overrun_q, overrun_d;

  logic [IDX_W-1:0]   pick_winner;
  logic               pick_valid;
  logic [REQ_MAX-1:0] req_ext;
  logic               owner_req;

  dl_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  // Widen req so the owner index can address it at its natural width.
  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end
  assign owner_req = req_ext[owner_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    overrun_d  = 1'b0;

    case (state_q)
      // TURN always lasts one cycle, so it arbitrates exactly like IDLE.
      IDLE, TURN: begin
        if (pick_valid) begin
          state_d    = OWNED;
          grant_d    = NREQ'(1) << pick_winner;
          hold_cnt_d = HOLD_W'(1);
          owner_d    = pick_winner;
          // Pointer moves past the winner so a force-released owner that is
          // still requesting loses to any other active requester.
          rr_ptr_d   = (pick_winner == IDX_W'(NREQ - 1)) ? '0
                                                         : pick_winner + IDX_W'(1);
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end

      OWNED: begin
        // A dropped request wins over hold expiry: normal release, no overrun.
        if (!owner_req) begin
          state_d = TURN;
          grant_d = '0;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
          state_d   = TURN;
          grant_d   = '0;
          overrun_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: the reset branch sits in the sensitivity list so grant drops the
  // moment RESET rises, not at the next clock edge.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      overrun_q  <= overrun_d;
    end
  end

  assign grant     = grant_q;
  assign DataOut   = grant_q[BRIDGE_IDX];
  assign bus_busy  = (state_q != IDLE);
  assign precharge = (state_q == TURN);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dl_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dl_bus_arbiter
// Scoreboard bench for dl_bus_arbiter (NREQ=4, MAX_HOLD=4, BRIDGE_IDX=0).
// Each step drives req, pushes the expected post-edge outputs, and after the
// edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_dl_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic            CLK2;
  logic            RESET;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            DataOut;
  logic            bus_busy;
  logic            precharge;
  logic            overrun;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic            pre;
    logic            ovr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  dl_bus_arbiter #(
    .NREQ       (NREQ),
    .MAX_HOLD   (MAX_HOLD),
    .BRIDGE_IDX (0)
  ) dut (
    .CLK2      (CLK2),
    .RESET     (RESET),
    .req       (req),
    .grant     (grant),
    .DataOut   (DataOut),
    .bus_busy  (bus_busy),
    .precharge (precharge),
    .overrun   (overrun)
  );

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, "/grant"},     32'(grant),     32'(e.grant));
    check({t, "/DataOut"},   32'(DataOut),   32'(e.grant[0]));
    check({t, "/bus_busy"},  32'(bus_busy),  32'((|e.grant) | e.pre));
    check({t, "/precharge"}, 32'(precharge), 32'(e.pre));
    check({t, "/overrun"},   32'(overrun),   32'(e.ovr));
  endtask

  // Drive req for one cycle, record the expected result of the coming edge,
  // then compare just after that edge.
  task automatic step(input string tag, input logic [NREQ-1:0] r,
                      input logic [NREQ-1:0] g, input logic pre, input logic ovr);
    exp_t e;
    req     = r;
    e.grant = g;
    e.pre   = pre;
    e.ovr   = ovr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK2);
    #1;
    pop_check();
  endtask

  initial begin
    RESET = 1'b1;
    req   = 4'b1111;

    // Reset held with all requests active: nothing granted.
    repeat (2) @(posedge CLK2);
    #1;
    check("rst/grant",     32'(grant),     32'h0);
    check("rst/DataOut",   32'(DataOut),   32'h0);
    check("rst/bus_busy",  32'(bus_busy),  32'h0);
    check("rst/precharge", 32'(precharge), 32'h0);
    check("rst/overrun",   32'(overrun),   32'h0);
    RESET = 1'b0;

    // Round robin with all requesting: 4 owned cycles each, TURN with overrun.
    for (int o = 0; o < NREQ; o++) begin
      for (int c = 0; c < MAX_HOLD; c++)
        step($sformatf("rr%0d_own%0d", o, c), 4'b1111, 4'(1 << o), 1'b0, 1'b0);
      step($sformatf("rr%0d_turn", o), 4'b1111, 4'b0000, 1'b1, 1'b1);
    end
    step("rr_wrap",  4'b1111, 4'b0001, 1'b0, 1'b0);
    step("rr_rel",   4'b0000, 4'b0000, 1'b1, 1'b0);
    step("rr_idle",  4'b0000, 4'b0000, 1'b0, 1'b0);

    // Single short hold by the immediate latch.
    for (int c = 0; c < 3; c++)
      step($sformatf("hold_own%0d", c), 4'b0100, 4'b0100, 1'b0, 1'b0);
    step("hold_turn", 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("hold_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Lone requester held 10 cycles: forced release, then regranted.
    for (int c = 0; c < 10; c++) begin
      if (c % 5 == 4) step($sformatf("ovr_turn%0d", c), 4'b0010, 4'b0000, 1'b1, 1'b1);
      else            step($sformatf("ovr_own%0d", c),  4'b0010, 4'b0010, 1'b0, 1'b0);
    end
    step("ovr_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Release on the same cycle the hold expires: plain release.
    for (int c = 0; c < MAX_HOLD; c++)
      step($sformatf("sim_own%0d", c), 4'b1000, 4'b1000, 1'b0, 1'b0);
    step("sim_turn", 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("sim_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Other requests do not preempt the owner.
    step("np_own0",  4'b0001, 4'b0001, 1'b0, 1'b0);
    step("np_own1",  4'b0101, 4'b0001, 1'b0, 1'b0);
    step("np_own2",  4'b0101, 4'b0001, 1'b0, 1'b0);
    step("np_turn",  4'b0100, 4'b0000, 1'b1, 1'b0);
    step("np_next",  4'b0100, 4'b0100, 1'b0, 1'b0);
    step("np_rel",   4'b0000, 4'b0000, 1'b1, 1'b0);
    step("np_idle",  4'b0000, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an owned cycle.
    step("ar_own", 4'b0010, 4'b0010, 1'b0, 1'b0);
    #3;
    RESET = 1'b1;
    #1;
    check("ar/grant",    32'(grant),    32'h0);
    check("ar/DataOut",  32'(DataOut),  32'h0);
    check("ar/bus_busy", 32'(bus_busy), 32'h0);
    #1;
    RESET = 1'b0;
    // Pointer restarts at 0 after reset.
    step("ar_regrant", 4'b1111, 4'b0001, 1'b0, 1'b0);
    step("ar_rel",     4'b0000, 4'b0000, 1'b1, 1'b0);
    step("ar_idle",    4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
